// File: rtl/multi_mode_filter.sv
// Per-channel input noise filter: bypass, half-cycle glitch rejection, or N-sample persistence debounce.
// Optional GLITCH_STATS_EN adds a saturating rejected-glitch event counter.

module multi_mode_filter_lane #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       mode_q,
    input  logic             mode_chg,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] min_len,
    input  logic             in_bit,
    input  logic             in180_bit,
`ifdef GLITCH_STATS_EN
    output logic             glitch,
`endif
    output logic             out_bit
);
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_PERS = 2'b10;

    logic             dly, dly180;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so the threshold compare sees cnt+1 before it could wrap.
    assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

`ifdef GLITCH_STATS_EN
    assign glitch = in_valid && !mode_chg &&
                    (((mode_q == MODE_PERS) && (in_bit == out_bit) && (cnt != '0)) ||
                     ((mode_q == MODE_HALF) && (in_bit || dly) && !dly180 && !out_bit));
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_bit <= 1'b0;
            dly     <= 1'b0;
            dly180  <= 1'b0;
            cnt     <= '0;
        end else if (mode_chg) begin
            dly     <= 1'b0;
            dly180  <= 1'b0;
            cnt     <= '0;
        end else if (in_valid) begin
            case (mode_q)
                MODE_HALF: begin
                    out_bit <= (out_bit | dly | in_bit) & dly180;
                    dly     <= in_bit;
                    dly180  <= in180_bit;
                end
                MODE_PERS: begin
                    if (in_bit == out_bit) begin
                        cnt <= '0;
                    end else if (cnt_inc >= {1'b0, min_len}) begin
                        out_bit <= in_bit;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_inc[CNT_W-1:0];
                    end
                end
                default: out_bit <= in_bit;
            endcase
        end
    end
endmodule

module multi_mode_filter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] min_len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] indata,
    input  logic [WIDTH-1:0] indata180,
    output logic             out_valid,
    output logic [WIDTH-1:0] outdata
`ifdef GLITCH_STATS_EN
    ,
    input  logic             glitch_clear,
    output logic [15:0]      glitch_count
`endif
);
    logic [1:0] mode_q;
    logic       mode_chg;
    logic [1:0] vld_pipe;

    assign mode_chg    = (mode != mode_q);
    assign vld_pipe[0] = in_valid;
    assign out_valid   = vld_pipe[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= 2'b00;
            vld_pipe[1] <= 1'b0;
        end else begin
            mode_q      <= mode;
            vld_pipe[1] <= vld_pipe[0];
        end
    end

`ifdef GLITCH_STATS_EN
    logic [WIDTH-1:0] lane_glitch;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        multi_mode_filter_lane #(.CNT_W(CNT_W)) u_lane (
            .clock     (clock),
            .reset_n   (reset_n),
            .mode_q    (mode_q),
            .mode_chg  (mode_chg),
            .in_valid  (in_valid),
            .min_len   (min_len),
            .in_bit    (indata[i]),
            .in180_bit (indata180[i]),
`ifdef GLITCH_STATS_EN
            .glitch    (lane_glitch[i]),
`endif
            .out_bit   (outdata[i])
        );
    end

`ifdef GLITCH_STATS_EN
    // One event per strobe regardless of how many channels rejected at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            glitch_count <= '0;
        else if (glitch_clear)
            glitch_count <= '0;
        else if ((|lane_glitch) && (glitch_count != 16'hFFFF))
            glitch_count <= glitch_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_multi_mode_filter.sv
// Directed bench for multi_mode_filter; glitch-counter checks compile in only with GLITCH_STATS_EN.

module tb_multi_mode_filter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [3:0]  min_len;
    logic        in_valid;
    logic [31:0] indata, indata180;
    logic        out_valid;
    logic [31:0] outdata;
`ifdef GLITCH_STATS_EN
    logic        glitch_clear;
    logic [15:0] glitch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multi_mode_filter #(.WIDTH(32), .CNT_W(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .mode         (mode),
        .min_len      (min_len),
        .in_valid     (in_valid),
        .indata       (indata),
        .indata180    (indata180),
`ifdef GLITCH_STATS_EN
        .glitch_clear (glitch_clear),
        .glitch_count (glitch_count),
`endif
        .out_valid    (out_valid),
        .outdata      (outdata)
    );

    task automatic strobe(input logic [31:0] d, input logic [31:0] d180);
        indata = d; indata180 = d180; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        @(posedge clock); #1;
    endtask

    task automatic zero_out();
        set_mode(2'b00);
        strobe(32'h0, 32'h0);
    endtask

`ifdef GLITCH_STATS_EN
    task automatic clear_glitch();
        glitch_clear = 1'b1;
        @(posedge clock); #1;
        glitch_clear = 1'b0;
    endtask
`endif

    task automatic test_reset();
        #1;
        n_checks++; if (outdata !== 32'h0) begin n_fail++; $display("FAIL reset_outdata got %h want %h", outdata, 32'h0); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        #11 reset_n = 1'b1;
        mode = 2'b00; indata = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (outdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL pre_reset_outdata got %h want ffffffff", outdata); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (outdata !== 32'h0) begin n_fail++; $display("FAIL async_reset_outdata got %h want 0", outdata); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_out_valid got %b want 0", out_valid); end
        in_valid = 1'b0; indata = 32'h0;
        #2 reset_n = 1'b1;
    endtask

    task automatic test_bypass();
        set_mode(2'b00);
        indata = 32'hA5A5_A5A5; in_valid = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (outdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_a5 got %h want a5a5a5a5", outdata); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid got %b want 1", out_valid); end
        indata = 32'h5A5A_5A5A;
        @(posedge clock); #1;
        n_checks++; if (outdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL bypass_5a got %h want 5a5a5a5a", outdata); end
        in_valid = 1'b0; indata = 32'h0;
        @(posedge clock); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_idle_valid got %b want 0", out_valid); end
        n_checks++; if (outdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL bypass_hold got %h want 5a5a5a5a", outdata); end
        set_mode(2'b11);
        strobe(32'h1234_5678, 32'h0);
        n_checks++; if (outdata !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_mode3 got %h want 12345678", outdata); end
    endtask

    task automatic test_half_cycle();
        zero_out();
        set_mode(2'b01);
        strobe(32'h1, 32'h0);
        n_checks++; if (outdata[0] !== 1'b0) begin n_fail++; $display("FAIL half_rise_only_a got %b want 0", outdata[0]); end
        strobe(32'h0, 32'h0);
        n_checks++; if (outdata[0] !== 1'b0) begin n_fail++; $display("FAIL half_rise_only_b got %b want 0", outdata[0]); end
        strobe(32'h1, 32'h1);
        n_checks++; if (outdata[0] !== 1'b0) begin n_fail++; $display("FAIL half_both_1 got %b want 0", outdata[0]); end
        strobe(32'h1, 32'h1);
        n_checks++; if (outdata[0] !== 1'b1) begin n_fail++; $display("FAIL half_both_2 got %b want 1", outdata[0]); end
`ifdef GLITCH_STATS_EN
        n_checks++; if (glitch_count !== 16'd3) begin n_fail++; $display("FAIL half_glitch_count got %0d want 3", glitch_count); end
`endif
    endtask

    task automatic test_persistence();
`ifdef GLITCH_STATS_EN
        clear_glitch();
`endif
        zero_out();
        min_len = 4'd3;
        set_mode(2'b10);
        strobe(32'h20, 32'h0);
        strobe(32'h20, 32'h0);
        n_checks++; if (outdata[5] !== 1'b0) begin n_fail++; $display("FAIL pers_short_high got %b want 0", outdata[5]); end
        strobe(32'h0, 32'h0);
        n_checks++; if (outdata !== 32'h0) begin n_fail++; $display("FAIL pers_short_after got %h want 0", outdata); end
`ifdef GLITCH_STATS_EN
        n_checks++; if (glitch_count !== 16'd1) begin n_fail++; $display("FAIL pers_glitch_count got %0d want 1", glitch_count); end
`endif
        strobe(32'h20, 32'h0);
        strobe(32'h20, 32'h0);
        n_checks++; if (outdata[5] !== 1'b0) begin n_fail++; $display("FAIL pers_2nd_strobe got %b want 0", outdata[5]); end
        strobe(32'h20, 32'h0);
        n_checks++; if (outdata !== 32'h20) begin n_fail++; $display("FAIL pers_3rd_strobe got %h want 20", outdata); end
        min_len = 4'd1;
        strobe(32'h0, 32'h0);
        n_checks++; if (outdata[5] !== 1'b0) begin n_fail++; $display("FAIL pers_min1 got %b want 0", outdata[5]); end
        min_len = 4'd0;
        strobe(32'h20, 32'h0);
        n_checks++; if (outdata[5] !== 1'b1) begin n_fail++; $display("FAIL pers_min0 got %b want 1", outdata[5]); end
        strobe(32'h0, 32'h0);
    endtask

    task automatic test_slow_strobe();
        min_len = 4'd15;
        indata = 32'h8000_0000;
        for (int k = 1; k <= 15; k++) begin
            repeat (3) @(posedge clock);
            #1;
            n_checks++; if (outdata[31] !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL slow_idle k=%0d got out=%b vld=%b want 0 0", k, outdata[31], out_valid);
            end
            strobe(32'h8000_0000, 32'h0);
            n_checks++; if (outdata[31] !== (k == 15)) begin
                n_fail++; $display("FAIL slow_strobe k=%0d got %b want %b", k, outdata[31], (k == 15));
            end
        end
    endtask

    task automatic test_mode_change();
        min_len = 4'd1;
        strobe(32'h0, 32'h0);
        min_len = 4'd3;
        strobe(32'h2, 32'h0);
        strobe(32'h2, 32'h0);
        mode = 2'b00; indata = 32'h2; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL chg_valid got %b want 1", out_valid); end
        n_checks++; if (outdata !== 32'h0) begin n_fail++; $display("FAIL chg_hold got %h want 0", outdata); end
        set_mode(2'b10);
        strobe(32'h2, 32'h0);
        strobe(32'h2, 32'h0);
        n_checks++; if (outdata[1] !== 1'b0) begin n_fail++; $display("FAIL chg_cnt_cleared got %b want 0", outdata[1]); end
        strobe(32'h2, 32'h0);
        n_checks++; if (outdata[1] !== 1'b1) begin n_fail++; $display("FAIL chg_recount got %b want 1", outdata[1]); end
`ifdef GLITCH_STATS_EN
        clear_glitch();
        strobe(32'h0, 32'h0);
        strobe(32'h2, 32'h0);
        n_checks++; if (glitch_count !== 16'd1) begin n_fail++; $display("FAIL clr_pre got %0d want 1", glitch_count); end
        strobe(32'h0, 32'h0);
        glitch_clear = 1'b1;
        strobe(32'h2, 32'h0);
        glitch_clear = 1'b0;
        n_checks++; if (glitch_count !== 16'd0) begin n_fail++; $display("FAIL clr_wins got %0d want 0", glitch_count); end
`endif
    endtask

    initial begin
        reset_n = 1'b0; mode = 2'b00; min_len = 4'd0; in_valid = 1'b0;
        indata = 32'h0; indata180 = 32'h0;
`ifdef GLITCH_STATS_EN
        glitch_clear = 1'b0;
`endif
        test_reset();
        test_bypass();
        test_half_cycle();
        test_persistence();
        test_slow_strobe();
        test_mode_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
